// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection and bubble count.
// Ports: clk, rst_n (sync, active-low), stall, flush, id_* in, ex_* out,
//   ex_write_reg, load_use_stall (comb), bubble_count (saturating).
module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_dest,
  input  logic              id_jump_link,
  input  logic [3:0]        id_alu_op,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [DATA_W-1:0] id_pc_plus4,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_dest,
  output logic              ex_jump_link,
  output logic [3:0]        ex_alu_op,
  output logic              ex_uses_rt,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_shamt,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [REG_W-1:0]  ex_write_reg,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_dest;
    logic              jump_link;
    logic [3:0]        alu_op;
    logic              uses_rt;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] pc_plus4;
    logic [REG_W-1:0]  write_reg;
  } ex_t;

  ex_t              ex_q, ex_d, cap;
  logic [CNT_W-1:0] bub_q, bub_d;
  logic             hazard;

  // Control bits are gated by id_valid so an empty slot never writes.
  always_comb begin
    cap            = '0;
    cap.valid      = id_valid;
    cap.reg_write  = id_valid & id_reg_write;
    cap.mem_to_reg = id_valid & id_mem_to_reg;
    cap.mem_write  = id_valid & id_mem_write;
    cap.alu_src    = id_valid & id_alu_src;
    cap.reg_dest   = id_valid & id_reg_dest;
    cap.jump_link  = id_valid & id_jump_link;
    cap.alu_op     = id_valid ? id_alu_op : 4'h0;
    cap.uses_rt    = id_valid & id_uses_rt;
    cap.rd1        = id_rd1;
    cap.rd2        = id_rd2;
    cap.rs         = id_rs;
    cap.rt         = id_rt;
    cap.rd         = id_rd;
    cap.imm        = id_imm;
    cap.shamt      = id_shamt;
    cap.pc_plus4   = id_pc_plus4;
    cap.write_reg  = id_jump_link ? REG_W'(31) :
                     id_reg_dest  ? id_rd : id_rt;
  end

  // Load in EX whose destination feeds the instruction in ID.
  assign hazard = ex_q.valid & ex_q.mem_to_reg
                & (ex_q.write_reg != '0) & id_valid
                & ((ex_q.write_reg == id_rs)
                   | (id_uses_rt & (ex_q.write_reg == id_rt)));

  assign load_use_stall = rst_n & hazard & ~flush & ~stall;

  always_comb begin
    ex_d  = ex_q;
    bub_d = bub_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
      if (~&bub_q) bub_d = bub_q + CNT_W'(1);
    end else begin
      ex_d = cap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      bub_q <= '0;
    end else begin
      ex_q  <= ex_d;
      bub_q <= bub_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_dest   = ex_q.reg_dest;
  assign ex_jump_link  = ex_q.jump_link;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_uses_rt    = ex_q.uses_rt;
  assign ex_rd1        = ex_q.rd1;
  assign ex_rd2        = ex_q.rd2;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_imm        = ex_q.imm;
  assign ex_shamt      = ex_q.shamt;
  assign ex_pc_plus4   = ex_q.pc_plus4;
  assign ex_write_reg  = ex_q.write_reg;
  assign bubble_count  = bub_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register.
// Directed vectors; monitor pops expected state each cycle.
module tb_id_ex_register;

  typedef struct packed {
    logic v, rw, m2r, mw, asrc, rdst, jl;
    logic [3:0]  aop;
    logic        urt;
    logic [31:0] rd1, rd2;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [31:0] pc;
  } vec_t;

  typedef struct packed {
    logic        lus;
    vec_t        ex;
    logic [4:0]  wr;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  vec_t iv = '0;

  logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write;
  logic        ex_alu_src, ex_reg_dest, ex_jump_link, ex_uses_rt;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc_plus4;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt, ex_write_reg;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  int checks = 0;
  int failures = 0;
  exp_t  exp_q[$];
  string nm_q[$];

  always #5 clk = ~clk;

  id_ex_register dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(iv.v), .id_reg_write(iv.rw),
    .id_mem_to_reg(iv.m2r), .id_mem_write(iv.mw),
    .id_alu_src(iv.asrc), .id_reg_dest(iv.rdst),
    .id_jump_link(iv.jl), .id_alu_op(iv.aop),
    .id_uses_rt(iv.urt), .id_rd1(iv.rd1), .id_rd2(iv.rd2),
    .id_rs(iv.rs), .id_rt(iv.rt), .id_rd(iv.rd),
    .id_imm(iv.imm), .id_shamt(iv.sh), .id_pc_plus4(iv.pc),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_dest(ex_reg_dest),
    .ex_jump_link(ex_jump_link), .ex_alu_op(ex_alu_op),
    .ex_uses_rt(ex_uses_rt), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_shamt(ex_shamt),
    .ex_pc_plus4(ex_pc_plus4), .ex_write_reg(ex_write_reg),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  function automatic vec_t mk(
    logic [6:0] ctl, logic [3:0] aop, logic urt,
    logic [31:0] rd1, logic [31:0] rd2,
    logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
    logic [31:0] imm, logic [31:0] pc);
    vec_t r;
    r = '0;
    {r.v, r.rw, r.m2r, r.mw, r.asrc, r.rdst, r.jl} = ctl;
    r.aop = aop; r.urt = urt;
    r.rd1 = rd1; r.rd2 = rd2;
    r.rs = rs; r.rt = rt; r.rd = rd;
    r.imm = imm; r.sh = imm[10:6]; r.pc = pc;
    return r;
  endfunction

  task automatic step(
    input string nm, input vec_t v,
    input logic st, input logic fl, input logic rn,
    input logic lus, input vec_t ee,
    input logic [4:0] wr, input logic [15:0] cnt);
    exp_t e;
    @(negedge clk);
    iv = v; stall = st; flush = fl; rst_n = rn;
    e.lus = lus; e.ex = ee; e.wr = wr; e.cnt = cnt;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: stall flag sampled before the edge, EX state after it.
  initial begin
    exp_t  a, e;
    string n;
    forever begin
      @(negedge clk);
      #4;
      a.lus = load_use_stall;
      @(posedge clk);
      #1;
      a.ex = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write,
              ex_alu_src, ex_reg_dest, ex_jump_link, ex_alu_op,
              ex_uses_rt, ex_rd1, ex_rd2, ex_rs, ex_rt, ex_rd,
              ex_imm, ex_shamt, ex_pc_plus4};
      a.wr  = ex_write_reg;
      a.cnt = bubble_count;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got %h expected %h", n, a, e);
        end
      end
    end
  end

  localparam logic [6:0] ADDU = 7'b1100010;
  localparam logic [6:0] LW   = 7'b1110100;
  localparam logic [6:0] ORI  = 7'b1100100;
  localparam logic [6:0] JAL  = 7'b1100001;

  initial begin
    vec_t Z, A, L9, B, L0, C, L4, O, J, NV, NVe;
    Z   = '0;
    A   = mk(ADDU, 4'h2, 1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd8,
             32'h0, 32'h4);
    L9  = mk(LW, 4'h0, 1'b0, 32'h100, 32'h0, 5'd3, 5'd9, 5'd0,
             32'h10, 32'h8);
    B   = mk(ADDU, 4'h2, 1'b1, 32'h11, 32'h22, 5'd9, 5'd1, 5'd10,
             32'h0, 32'hC);
    L0  = mk(LW, 4'h0, 1'b0, 32'h100, 32'h0, 5'd3, 5'd0, 5'd0,
             32'h4, 32'h10);
    C   = mk(ADDU, 4'h2, 1'b1, 32'h0, 32'h0, 5'd0, 5'd0, 5'd11,
             32'h0, 32'h14);
    L4  = mk(LW, 4'h0, 1'b0, 32'h200, 32'h0, 5'd6, 5'd4, 5'd0,
             32'h8, 32'h18);
    O   = mk(ORI, 4'h3, 1'b0, 32'h55, 32'h66, 5'd5, 5'd4, 5'd0,
             32'hFF, 32'h1C);
    J   = mk(JAL, 4'h0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
             32'h40, 32'h20);
    NV  = mk(7'b0100010, 4'h2, 1'b0, 32'hAA, 32'hBB, 5'd1, 5'd12,
             5'd12, 32'h7C0, 32'h24);
    NVe = NV;
    {NVe.rw, NVe.m2r, NVe.mw, NVe.asrc, NVe.rdst, NVe.jl} = '0;
    NVe.aop = 4'h0;

    step("reset0", A, 0, 0, 0, 0, Z, 5'd0, 16'd0);
    step("reset1", A, 0, 0, 0, 0, Z, 5'd0, 16'd0);
    step("addu",   A, 0, 0, 1, 0, A, 5'd8, 16'd0);
    step("lw9",    L9, 0, 0, 1, 0, L9, 5'd9, 16'd0);
    step("hazard", B, 0, 0, 1, 1, Z, 5'd0, 16'd1);
    step("after",  B, 0, 0, 1, 0, B, 5'd10, 16'd1);
    step("lw0",    L0, 0, 0, 1, 0, L0, 5'd0, 16'd1);
    step("use0",   C, 0, 0, 1, 0, C, 5'd11, 16'd1);
    step("lw4",    L4, 0, 0, 1, 0, L4, 5'd4, 16'd1);
    step("ori_nrt", O, 0, 0, 1, 0, O, 5'd4, 16'd1);
    step("lw9b",   L9, 0, 0, 1, 0, L9, 5'd9, 16'd1);
    step("flushhz", B, 0, 1, 1, 0, Z, 5'd0, 16'd1);
    step("lw9c",   L9, 0, 0, 1, 0, L9, 5'd9, 16'd1);
    step("stall1", B, 1, 0, 1, 0, L9, 5'd9, 16'd1);
    step("stall2", B, 1, 0, 1, 0, L9, 5'd9, 16'd1);
    step("stall3", B, 1, 0, 1, 0, L9, 5'd9, 16'd1);
    step("poststl", B, 0, 0, 1, 1, Z, 5'd0, 16'd2);
    step("capB",   B, 0, 0, 1, 0, B, 5'd10, 16'd2);
    step("jal",    J, 0, 0, 1, 0, J, 5'd31, 16'd2);
    step("invalid", NV, 0, 0, 1, 0, NVe, 5'd12, 16'd2);

    @(negedge clk);
    force dut.bub_q = 16'hFFFE;
    #1 release dut.bub_q;

    step("lw9d",   L9, 0, 0, 1, 0, L9, 5'd9, 16'hFFFE);
    step("hz_top", B, 0, 0, 1, 1, Z, 5'd0, 16'hFFFF);
    step("lw9e",   L9, 0, 0, 1, 0, L9, 5'd9, 16'hFFFF);
    step("hz_sat", B, 0, 0, 1, 1, Z, 5'd0, 16'hFFFF);
    step("lw9f",   L9, 0, 0, 1, 0, L9, 5'd9, 16'hFFFF);
    step("rst_hz", B, 0, 0, 0, 0, Z, 5'd0, 16'd0);
    step("addu2",  A, 0, 0, 1, 0, A, 5'd8, 16'd0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
